pwm_carrier_mod: RTL and testbench

Unipolar sine-triangle modulator for one H-bridge power unit. It compares a signed modulation reference against an up/down triangular carrier and produces the 2-bit `igbt_control` upper-switch command consumed by the downstream dead-time gate driver. It also provides carrier phase alignment across cascaded units and double-update shadowing of the reference. Fault and stop gating ensure the unit starts cleanly on a carrier valley.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_carrier_mod_if.sv | 29 ++
 rtl/pwm_carrier.sv | 68 ++++++
 rtl/pwm_carrier_mod.sv | 154 +++++++++++++++
 tb/tb_pwm_carrier_mod.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the unipolar sine-triangle modulator.
// Holds the FSM state type, the default carrier/pulse parameters and the Q15 offset.
package pwm_pkg;

  localparam int unsigned CarrMaxDef  = 2000;   // carrier peak count
  localparam int unsigned CntWDef     = 12;     // carrier counter width
  localparam int unsigned MinPulseDef = 40;     // minimum pulse in clk (optional clamp)
  localparam int unsigned Q15Offset   = 32768;  // maps signed Q15 onto 0..65535

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun
  } pwm_state_e;

endpackage

// File: rtl/pwm_carrier_mod_if.sv
// Control/status bundle of one H-bridge modulator.
//   master: drives start_stop, err_unit, sync, phase_offset, ref_valid, ref_data
//   slave : drives ref_ready, igbt_control, carr_peak, carr_valley, ref_upd, run
interface pwm_carrier_mod_if #(
  parameter int unsigned CntW = pwm_pkg::CntWDef
);
  logic            start_stop;
  logic            err_unit;
  logic            sync;
  logic [CntW-1:0] phase_offset;
  logic            ref_valid;
  logic [15:0]     ref_data;
  logic            ref_ready;
  logic [1:0]      igbt_control;
  logic            carr_peak;
  logic            carr_valley;
  logic            ref_upd;
  logic            run;

  modport master (
    output start_stop, err_unit, sync, phase_offset, ref_valid, ref_data,
    input  ref_ready, igbt_control, carr_peak, carr_valley, ref_upd, run
  );

  modport slave (
    input  start_stop, err_unit, sync, phase_offset, ref_valid, ref_data,
    output ref_ready, igbt_control, carr_peak, carr_valley, ref_upd, run
  );
endinterface

// File: rtl/pwm_carrier.sv
// Up/down triangle carrier: 0 -> CarrMax -> 1 -> 0 ..., period 2*CarrMax clk.
//   clk, rst_n      : clock, async active-low reset
//   sync_i          : reload count from phase_offset_i (clamped to CarrMax)
//   cnt_o, dir_o    : current count, direction (1 = up)
//   at_peak_o/at_valley_o : combinational, current count is CarrMax / 0
//   peak_o/valley_o : registered versions, aligned with the registered PWM outputs
module pwm_carrier
  import pwm_pkg::*;
#(
  parameter int unsigned CarrMax = CarrMaxDef,
  parameter int unsigned CntW    = CntWDef
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sync_i,
  input  logic [CntW-1:0] phase_offset_i,
  output logic [CntW-1:0] cnt_o,
  output logic            dir_o,
  output logic            at_peak_o,
  output logic            at_valley_o,
  output logic            peak_o,
  output logic            valley_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(CarrMax);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            up_q, up_d;
  logic            peak_q, valley_q;

  assign at_peak_o   = (cnt_q == CntMax);
  assign at_valley_o = (cnt_q == '0);

  always_comb begin
    up_d = up_q;
    if (at_peak_o) begin
      up_d = 1'b0;
    end else if (at_valley_o) begin
      up_d = 1'b1;
    end
    cnt_d = up_d ? cnt_q + CntW'(1) : cnt_q - CntW'(1);
    // Sync overrides counting; a clamped load at the peak must already head down.
    if (sync_i) begin
      cnt_d = (phase_offset_i > CntMax) ? CntMax : phase_offset_i;
      up_d  = (cnt_d != CntMax);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      up_q     <= 1'b1;
      peak_q   <= 1'b0;
      valley_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      peak_q   <= at_peak_o;
      valley_q <= at_valley_o;
    end
  end

  assign cnt_o    = cnt_q;
  assign dir_o    = up_q;
  assign peak_o   = peak_q;
  assign valley_o = valley_q;

endmodule

// File: rtl/pwm_carrier_mod.sv
// Unipolar sine-triangle modulator for one H-bridge unit.
// Captures a signed Q15 reference, scales it to carrier thresholds, shadows them on
// carrier peak/valley and compares against the carrier to drive the upper switches.
//   clk, rst_n : clock, async active-low reset
//   bus        : pwm_carrier_mod_if.slave (controls in, igbt_control/status out)
// Optional macro PWM_MIN_PULSE_EN clamps thresholds so no pulse is shorter than MinPulse.
module pwm_carrier_mod
  import pwm_pkg::*;
#(
  parameter int unsigned CarrMax  = CarrMaxDef,
  parameter int unsigned CntW     = CntWDef
`ifdef PWM_MIN_PULSE_EN
  ,
  parameter int unsigned MinPulse = MinPulseDef
`endif
) (
  input logic              clk,
  input logic              rst_n,
  pwm_carrier_mod_if.slave bus
);

  localparam int unsigned     ThrW    = CntW + 1;
  localparam int unsigned     ProdW   = 17 + CntW;
  localparam logic [ThrW-1:0] ThrMax  = ThrW'(CarrMax);
  localparam logic [ThrW-1:0] ThrHalf = ThrW'(CarrMax / 2);

  logic [CntW-1:0] cnt;
  logic            at_peak, at_valley, unused_dir;

  pwm_carrier #(
    .CarrMax(CarrMax),
    .CntW   (CntW)
  ) u_carrier (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_i        (bus.sync),
    .phase_offset_i(bus.phase_offset),
    .cnt_o         (cnt),
    .dir_o         (unused_dir),
    .at_peak_o     (at_peak),
    .at_valley_o   (at_valley),
    .peak_o        (bus.carr_peak),
    .valley_o      (bus.carr_valley)
  );

  // Capture and threshold computation
  logic [15:0]      pend_q;
  logic             pend_new_q;
  logic [16:0]      ref_off;
  logic [ProdW-1:0] prod;
  logic [ThrW-1:0]  thr_a_raw, thr_b_raw, thr_a_d, thr_b_d;
  logic [ThrW-1:0]  thr_a_q, thr_b_q, act_a_q, act_b_q;
  logic             thr_new_q, thr_new_d, evt, ref_upd_q;

  // Flipping the sign bit adds 32768 to a two's-complement Q15 value.
  assign ref_off   = {1'b0, ~pend_q[15], pend_q[14:0]};
  assign prod      = ProdW'(ref_off) * ProdW'(CarrMax);
  assign thr_a_raw = prod[ProdW-1:16];
  assign thr_b_raw = ThrMax - thr_a_raw;

`ifdef PWM_MIN_PULSE_EN
  localparam logic [ThrW-1:0] ClampLo  = ThrW'(MinPulse);
  localparam logic [ThrW-1:0] ClampHi  = ThrW'(CarrMax - MinPulse);
  localparam logic [ThrW-1:0] AlwaysOn = ThrW'(CarrMax + 1);

  always_comb begin
    thr_a_d = thr_a_raw;
    thr_b_d = thr_b_raw;
    if (thr_a_raw < ClampLo) thr_a_d = '0;
    else if (thr_a_raw > ClampHi) thr_a_d = AlwaysOn;
    if (thr_b_raw < ClampLo) thr_b_d = '0;
    else if (thr_b_raw > ClampHi) thr_b_d = AlwaysOn;
  end
`else
  assign thr_a_d = thr_a_raw;
  assign thr_b_d = thr_b_raw;
`endif

  assign evt = at_peak | at_valley;
  // A capture arriving on an update edge is kept pending for the following edge.
  assign thr_new_d = pend_new_q | (thr_new_q & ~evt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_new_q <= 1'b0;
      thr_a_q    <= ThrHalf;
      thr_b_q    <= ThrMax - ThrHalf;
      act_a_q    <= ThrHalf;
      act_b_q    <= ThrMax - ThrHalf;
      thr_new_q  <= 1'b0;
      ref_upd_q  <= 1'b0;
    end else begin
      if (bus.ref_valid) pend_q <= bus.ref_data;
      pend_new_q <= bus.ref_valid;
      thr_a_q    <= thr_a_d;
      thr_b_q    <= thr_b_d;
      thr_new_q  <= thr_new_d;
      ref_upd_q  <= evt & thr_new_q;
      if (evt && thr_new_q) begin
        act_a_q <= thr_a_q;
        act_b_q <= thr_b_q;
      end
    end
  end

  // Compare and FSM
  logic [1:0] cmp;
  logic       halt;
  pwm_state_e state_q;
  logic [1:0] igbt_q;
  logic       run_q;

  assign cmp  = {({1'b0, cnt} < act_b_q), ({1'b0, cnt} < act_a_q)};
  assign halt = bus.err_unit | ~bus.start_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      igbt_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      igbt_q <= '0;
      run_q  <= 1'b0;
      unique case (state_q)
        StIdle: if (!halt) state_q <= StArm;
        StArm: begin
          if (halt) begin
            state_q <= StIdle;
          end else if (at_valley) begin
            state_q <= StRun;
            run_q   <= 1'b1;
            igbt_q  <= cmp;
          end
        end
        StRun: begin
          if (halt) begin
            state_q <= StIdle;
          end else begin
            run_q  <= 1'b1;
            igbt_q <= cmp;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.igbt_control = igbt_q;
  assign bus.run          = run_q;
  assign bus.ref_upd      = ref_upd_q;
  assign bus.ref_ready    = 1'b1;

endmodule

// File: tb/tb_pwm_carrier_mod.sv
// Self-checking bench for pwm_carrier_mod: directed steps plus randomized traffic,
// checked every cycle against a phase-based behavioural model.
module tb_pwm_carrier_mod;

  localparam int CM     = 2000;
  localparam int PERIOD = 2 * CM;

  logic clk = 1'b0;
  logic rst_n;

  pwm_carrier_mod_if bus ();

  pwm_carrier_mod dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: carrier as a phase 0..PERIOD-1, counts derived from it.
  int       m_p, m_mode, m_pend, m_ca, m_cb, m_aa, m_ab;
  bit       m_pend_new, m_cnew;
  bit [1:0] m_igbt;
  bit       m_peak, m_valley, m_upd, m_run;

  function automatic int tri_cnt(int p);
    return (p <= CM) ? p : PERIOD - p;
  endfunction

  function automatic int clamp_thr(int t);
`ifdef PWM_MIN_PULSE_EN
    if (t < 40) return 0;
    if (t > CM - 40) return CM + 1;
`endif
    return t;
  endfunction

  function automatic int raw_a(int r);
    longint x;
    x = longint'(r + 32768) * CM;
    return int'(x / 65536);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_init();
    m_p = 0; m_mode = 0; m_pend = 0; m_pend_new = 0; m_cnew = 0;
    m_ca = clamp_thr(raw_a(0)); m_cb = clamp_thr(CM - raw_a(0));
    m_aa = m_ca; m_ab = m_cb;
    m_igbt = 0; m_peak = 0; m_valley = 0; m_upd = 0; m_run = 0;
  endtask

  task automatic model_step();
    int c, off;
    bit ev, halt;
    bit [1:0] cmpv;
    c    = tri_cnt(m_p);
    ev   = (c == 0) || (c == CM);
    halt = bus.err_unit || !bus.start_stop;
    cmpv = {bit'(c < m_ab), bit'(c < m_aa)};
    m_igbt = 0;
    m_run  = 0;
    if (m_mode == 0) begin
      if (!halt) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt) m_mode = 0;
      else if (c == 0) begin m_mode = 2; m_run = 1; m_igbt = cmpv; end
    end else begin
      if (halt) m_mode = 0;
      else begin m_run = 1; m_igbt = cmpv; end
    end
    m_peak   = (c == CM);
    m_valley = (c == 0);
    m_upd    = ev && m_cnew;
    if (m_upd) begin m_aa = m_ca; m_ab = m_cb; end
    m_cnew = m_pend_new || (m_cnew && !ev);
    m_ca   = clamp_thr(raw_a(m_pend));
    m_cb   = clamp_thr(CM - raw_a(m_pend));
    m_pend_new = bus.ref_valid;
    if (bus.ref_valid) m_pend = int'($signed(bus.ref_data));
    if (bus.sync) begin
      off = int'(bus.phase_offset);
      m_p = (off > CM) ? CM : off;
    end else begin
      m_p = (m_p + 1) % PERIOD;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cycle", 32'({bus.igbt_control, bus.carr_peak, bus.carr_valley, bus.ref_upd,
                        bus.run, bus.ref_ready}),
          32'({m_igbt, m_peak, m_valley, m_upd, m_run, 1'b1}));
  endtask

  task automatic wait_run(input string tag);
    for (int i = 0; i < 2 * PERIOD + 200 && !bus.run; i++) tick();
    check(tag, 32'(bus.run), 32'd1);
    check({tag, "_valley"}, 32'(bus.carr_valley), 32'd1);
  endtask

  task automatic wait_upd(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < PERIOD + 100 && !seen; i++) begin
      tick();
      seen = bus.ref_upd;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic measure(output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      h0 += int'(bus.igbt_control[0]);
      h1 += int'(bus.igbt_control[1]);
    end
  endtask

  task automatic send_ref(input logic [15:0] r);
    bus.ref_valid = 1'b1;
    bus.ref_data  = r;
    tick();
    bus.ref_valid = 1'b0;
  endtask

  initial begin
    int h0, h1, n, upds;
    bus.start_stop = 0; bus.err_unit = 0; bus.sync = 0; bus.phase_offset = '0;
    bus.ref_valid = 0; bus.ref_data = '0;
    rst_n = 1'b0;
    #12;
    check("rst_igbt", 32'(bus.igbt_control), 32'd0);
    check("rst_flags", 32'({bus.carr_peak, bus.carr_valley, bus.ref_upd, bus.run}), 32'd0);
    check("rst_ready", 32'(bus.ref_ready), 32'd1);
    model_init();
    @(negedge clk);
    rst_n = 1'b1;

    // Start with ref 0: both legs 1999 clk per period
    bus.start_stop = 1'b1;
    wait_run("start_run");
    measure(h0, h1);
    check("duty0_ref0", 32'(h0), 32'd1999);
    check("duty1_ref0", 32'(h1), 32'd1999);

    // ref = +0.5
    send_ref(16'd16384);
    wait_upd("upd_16384");
    measure(h0, h1);
    check("duty0_16384", 32'(h0), 32'd2999);
    check("duty1_16384", 32'(h1), 32'd999);

    // Fault mid-run, restart on a valley
    bus.err_unit = 1'b1;
    tick();
    bus.err_unit = 1'b0;
    check("err_off", 32'({bus.igbt_control, bus.run}), 32'd0);
    wait_run("err_resume");

    // Sync phase: clamp to peak, then valley timing for offsets 0 and 500
    bus.sync = 1'b1; bus.phase_offset = 12'd3000;
    tick();
    bus.sync = 1'b0;
    tick();
    check("sync_clamp_peak", 32'(bus.carr_peak), 32'd1);
    for (int k = 0; k < 2; k++) begin
      bus.sync = 1'b1; bus.phase_offset = (k == 0) ? 12'd0 : 12'd500;
      tick();
      bus.sync = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!bus.carr_valley && n < PERIOD + 10);
      check((k == 0) ? "sync0_valley" : "sync500_valley", 32'(n), (k == 0) ? 32'd1 : 32'd3501);
    end

    // Full-scale reference
    send_ref(16'h7fff);
    wait_upd("upd_max");
    measure(h0, h1);
`ifdef PWM_MIN_PULSE_EN
    check("duty0_max", 32'(h0), 32'd4000);
    check("duty1_max", 32'(h1), 32'd0);
`else
    check("duty0_max", 32'(h0), 32'd3997);
    check("duty1_max", 32'(h1), 32'd1);
`endif

    // Two writes within one half-period: one update, last value wins
    n = 0;
    do begin tick(); n++; end while (!bus.carr_valley && n < PERIOD + 10);
    check("valley_found", 32'(bus.carr_valley), 32'd1);
    send_ref(16'd8000);
    for (int i = 0; i < 20; i++) tick();
    send_ref(16'hc000);
    upds = 0;
    for (int i = 0; i < 2100; i++) begin
      tick();
      upds += int'(bus.ref_upd);
    end
    check("single_upd", 32'(upds), 32'd1);
    measure(h0, h1);
    check("duty0_m16384", 32'(h0), 32'd999);
    check("duty1_m16384", 32'(h1), 32'd2999);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      bus.ref_valid    = ($urandom_range(0, 39) == 0);
      bus.ref_data     = 16'($urandom);
      bus.sync         = ($urandom_range(0, 1499) == 0);
      bus.phase_offset = 12'($urandom_range(0, 4095));
      bus.err_unit     = ($urandom_range(0, 1999) == 0);
      bus.start_stop   = ($urandom_range(0, 2499) != 0);
      tick();
    end
    bus.ref_valid = 0; bus.sync = 0; bus.err_unit = 0; bus.start_stop = 1;

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'({bus.igbt_control, bus.carr_peak, bus.carr_valley, bus.ref_upd,
                             bus.run, bus.ref_ready}), 32'd1);
    model_init();
    @(negedge clk);
    rst_n = 1'b1;
    wait_run("rst_restart");
    measure(h0, h1);
    check("duty0_after_rst", 32'(h0), 32'd1999);
    check("duty1_after_rst", 32'(h1), 32'd1999);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
